// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET_MIN/SET_HOUR mode FSM for a wall clock, with btn_inc auto-repeat,
// inactivity timeout back to RUN and a blink phase for the field being set.
module clock_set_ctrl #(
  parameter int P_HOLD    = 50_000_000,
  parameter int P_RATE    = 10_000_000,
  parameter int P_TIMEOUT = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tic,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       hour_inc,
  output logic [1:0] mode,
  output logic       blink
);
  localparam int HMAX = (P_HOLD > P_RATE) ? P_HOLD : P_RATE;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int TW   = $clog2(P_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN = 2'b00, SET_MIN = 2'b01, SET_HOUR = 2'b10} state_t;

  state_t        r_state, w_state_next;
  logic          r_btn_low, r_rep, r_run_en, r_sec_clr, r_min_inc, r_hour_inc, r_blink;
  logic [HW-1:0] r_hold, w_hold_next;
  logic [TW-1:0] r_to, w_to_inc, w_to_next;
  logic          w_set, w_rise, w_tick, w_inc, w_timeout, w_chg, w_pulse, w_blink_next;

  // r_btn_low resets to 0, so a button already held through reset never looks like a fresh press
  always_comb begin
    w_set        = (r_state == SET_MIN) || (r_state == SET_HOUR);
    w_rise       = btn_inc & r_btn_low;
    w_tick       = btn_inc & (r_rep ? (r_hold == HW'(P_RATE)) : (r_hold == HW'(P_HOLD)));
    w_inc        = w_rise | w_tick;
    w_hold_next  = !btn_inc ? '0 : w_inc ? HW'(1) : (r_hold != '0) ? r_hold + 1'b1 : '0;
    w_to_inc     = (w_set && sec_tic && r_to != TW'(P_TIMEOUT)) ? r_to + 1'b1 : r_to;
    w_timeout    = w_set & ~btn_mode & ~btn_inc & (w_to_inc == TW'(P_TIMEOUT));
    w_state_next = btn_mode ? ((r_state == RUN) ? SET_MIN : (r_state == SET_MIN) ? SET_HOUR : RUN)
                 : (w_timeout || !(w_set || r_state == RUN)) ? RUN : r_state;
    w_chg        = w_state_next != r_state;
    w_to_next    = (btn_mode || btn_inc || w_chg) ? '0 : w_to_inc;
    w_pulse      = w_inc & ~btn_mode;
    w_blink_next = (w_chg || !w_set || w_inc) ? 1'b0 : r_blink ^ sec_tic;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_run_en   <= 1'b1;
      r_sec_clr  <= 1'b0;
      r_min_inc  <= 1'b0;
      r_hour_inc <= 1'b0;
      r_blink    <= 1'b0;
      r_hold     <= '0;
      r_rep      <= 1'b0;
      r_to       <= '0;
      r_btn_low  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_run_en   <= w_state_next == RUN;
      r_sec_clr  <= (r_state == RUN) && (w_state_next == SET_MIN);
      r_min_inc  <= w_pulse && (r_state == SET_MIN);
      r_hour_inc <= w_pulse && (r_state == SET_HOUR);
      r_blink    <= w_blink_next;
      r_hold     <= w_hold_next;
      r_rep      <= btn_inc & (r_rep | w_tick);
      r_to       <= w_to_next;
      r_btn_low  <= ~btn_inc;
    end
  end

  assign run_en   = r_run_en;
  assign sec_clr  = r_sec_clr;
  assign min_inc  = r_min_inc;
  assign hour_inc = r_hour_inc;
  assign mode     = r_state;
  assign blink    = r_blink;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed stimulus pushes cycle-stamped expected outputs; a monitor
// compares them and flags any output event nobody expected.
module tb_clock_set_ctrl;
  logic       clk = 1'b0;
  logic       reset, sec_tic, btn_mode, btn_inc;
  logic       run_en, sec_clr, min_inc, hour_inc, blink;
  logic [1:0] mode;

  // vector layout: {mode, run_en, sec_clr, min_inc, hour_inc, blink}
  localparam logic [6:0] RUN_Q  = 7'b00_1_0_0_0_0;
  localparam logic [6:0] SMIN_E = 7'b01_0_1_0_0_0;
  localparam logic [6:0] SMIN_Q = 7'b01_0_0_0_0_0;
  localparam logic [6:0] SMIN_B = 7'b01_0_0_0_0_1;
  localparam logic [6:0] MIN_P  = 7'b01_0_0_1_0_0;
  localparam logic [6:0] SHR_Q  = 7'b10_0_0_0_0_0;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_mode = 2'b00;

  clock_set_ctrl #(.P_HOLD(20), .P_RATE(5), .P_TIMEOUT(3)) dut (
    .clk(clk), .reset(reset), .sec_tic(sec_tic), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .run_en(run_en), .sec_clr(sec_clr), .min_inc(min_inc), .hour_inc(hour_inc),
    .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [6:0] a, input logic [6:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, a, x);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic i, input logic s);
    @(negedge clk);
    reset = r;
    btn_mode = m;
    btn_inc = i;
    sec_tic = s;
  endtask

  task automatic expect_at(input int c, input logic [6:0] v);
    q.push_back('{c, v});
  endtask

  initial begin
    logic [6:0] act;
    exp_t       e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        act = {mode, run_en, sec_clr, min_inc, hour_inc, blink};
        checks++;
        if (min_inc && hour_inc) begin
          failures++;
          $display("FAIL both_inc cyc=%0d got=%b want no overlap", cyc, act);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++;
          failures++;
          $display("FAIL missed cyc=%0d got=none want=%b", e.cyc, e.v);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
          e = q.pop_front();
          chk($sformatf("cyc%0d", cyc), act, e.v);
        end else if (sec_clr || min_inc || hour_inc || mode != prev_mode) begin
          checks++;
          failures++;
          $display("FAIL unexpected cyc=%0d got=%b want=no event", cyc, act);
        end
        prev_mode = mode;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int r;
    reset = 1'b1;
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    sec_tic = 1'b0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_state", {mode, run_en, sec_clr, min_inc, hour_inc, blink}, RUN_Q);
    step(0, 0, 0, 0);
    mon_en = 1'b1;
    step(0, 0, 0, 0);
    // full mode cycle, sec_clr only on entering SET_MIN
    step(0, 1, 0, 0); expect_at(cyc + 1, SMIN_E);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_Q);
    step(0, 1, 0, 0); expect_at(cyc + 1, SHR_Q);
    step(0, 1, 0, 0); expect_at(cyc + 1, RUN_Q);
    step(0, 0, 0, 0);
    // auto-repeat: edge pulse plus ticks at offsets 20, 25, 30 within a 35-cycle hold
    step(0, 1, 0, 0); expect_at(cyc + 1, SMIN_E);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    r = cyc;
    expect_at(r + 1, MIN_P);
    expect_at(r + 21, MIN_P);
    expect_at(r + 26, MIN_P);
    expect_at(r + 31, MIN_P);
    repeat (34) step(0, 0, 1, 0);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_Q);
    step(0, 0, 0, 0);
    // mode press beats a coincident inc edge in SET_HOUR
    step(0, 1, 0, 0); expect_at(cyc + 1, SHR_Q);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0); expect_at(cyc + 1, RUN_Q);
    step(0, 0, 0, 0); expect_at(cyc + 1, RUN_Q);
    // btn_inc in RUN does nothing, pressed or held
    repeat (3) begin
      step(0, 0, 1, 0); expect_at(cyc + 1, RUN_Q);
      step(0, 0, 0, 0); expect_at(cyc + 1, RUN_Q);
    end
    repeat (25) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    // inactivity timeout after three tics, blink 0->1->0
    step(0, 1, 0, 0); expect_at(cyc + 1, SMIN_E);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_Q);
    step(0, 0, 0, 1); expect_at(cyc + 1, SMIN_B);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_B);
    step(0, 0, 0, 1); expect_at(cyc + 1, SMIN_Q);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_Q);
    step(0, 0, 0, 1); expect_at(cyc + 1, RUN_Q);
    step(0, 0, 0, 0); expect_at(cyc + 1, RUN_Q);
    // reset during auto-repeat, then a held button is not a new press
    step(0, 1, 0, 0); expect_at(cyc + 1, SMIN_E);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1); expect_at(cyc + 1, SMIN_B);
    step(0, 0, 1, 0);
    r = cyc;
    expect_at(r + 1, MIN_P);
    expect_at(r + 21, MIN_P);
    repeat (23) step(0, 0, 1, 0);
    step(1, 0, 1, 0); expect_at(cyc + 1, RUN_Q);
    step(0, 0, 1, 0); expect_at(cyc + 1, RUN_Q);
    repeat (5) step(0, 0, 1, 0);
    step(0, 1, 1, 0); expect_at(cyc + 1, SMIN_E);
    repeat (30) step(0, 0, 1, 0);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_Q);
    step(0, 0, 1, 0); expect_at(cyc + 1, MIN_P);
    step(0, 0, 0, 0); expect_at(cyc + 1, SMIN_Q);
    for (int k = 0; k < 50 && q.size() > 0; k++) step(0, 0, 0, 0);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    repeat (3) step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have parameter P_HOLD, default 50_000_000, clk cycles btn_inc must stay held before auto-repeat starts.
REQ-002 The block SHALL have parameter P_RATE, default 10_000_000, clk cycles between auto-repeat pulses.
REQ-003 The block SHALL have parameter P_TIMEOUT, default 10, count of sec_tic pulses without button activity before an automatic return to RUN.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-006 The block SHALL have port sec_tic, input, 1 bit, one-cycle 1 Hz strobe.
REQ-007 The block SHALL have port btn_mode, input, 1 bit, debounced one-cycle press pulse.
REQ-008 The block SHALL have port btn_inc, input, 1 bit, debounced level, high while held.
REQ-009 The block SHALL have port run_en, output, 1 bit, enable for the sec/min/hour counter chain.
REQ-010 The block SHALL have port sec_clr, output, 1 bit, one-cycle clear pulse to the seconds counter.
REQ-011 The block SHALL have port min_inc, output, 1 bit, one-cycle increment pulse to the minute counter.
REQ-012 The block SHALL have port hour_inc, output, 1 bit, one-cycle increment pulse to the hour counter.
REQ-013 The block SHALL have port mode, output, 2 bits, state code: RUN=00, SET_MIN=01, SET_HOUR=10.
REQ-014 The block SHALL have port blink, output, 1 bit, display-blank phase for the field being set.

Function
REQ-015 The FSM SHALL use states RUN, SET_MIN and SET_HOUR; code 11 is illegal and SHALL go to RUN on the next cycle.
REQ-016 On a btn_mode pulse, the next state SHALL be RUN->SET_MIN->SET_HOUR->RUN, taking effect at the next clk edge.
REQ-017 run_en SHALL be registered and high only while the state is RUN (mode==00).
REQ-018 sec_clr SHALL pulse high for exactly one cycle, in the cycle after the RUN->SET_MIN transition; it SHALL not pulse on any other transition.
REQ-019 An inc event SHALL be either a btn_inc rising edge (using btn_inc registered against its previous-cycle value) or an auto-repeat tick.
REQ-020 The hold counter SHALL start at the btn_inc rising edge; after btn_inc has been high for P_HOLD cycles, an auto-repeat tick SHALL fire, then one tick every P_RATE cycles while btn_inc stays high.
REQ-021 The hold counter SHALL clear to 0 when btn_inc goes low, and no tick SHALL fire in that cycle.
REQ-022 Each inc event SHALL produce a registered one-cycle pulse, one cycle after the event: on min_inc in SET_MIN, on hour_inc in SET_HOUR; in RUN it SHALL produce no pulse.
REQ-023 If a btn_mode pulse and an inc event occur in the same cycle, the mode change SHALL win and the inc event SHALL be dropped.
REQ-024 min_inc and hour_inc SHALL never be high in the same cycle.
REQ-025 The timeout counter (width clog2(P_TIMEOUT+1)) SHALL clear on every btn_mode pulse, every inc event, and every state change.
REQ-026 The timeout counter SHALL increment on each sec_tic while in SET_MIN or SET_HOUR.
REQ-027 When the timeout counter reaches P_TIMEOUT, the state SHALL go to RUN at the next edge.
REQ-028 The timeout counter SHALL saturate and not wrap.
REQ-029 While btn_inc is held, the timeout counter SHALL stay cleared.
REQ-030 blink SHALL be 0 in RUN and SHALL clear to 0 on every state change.
REQ-031 In a set state, blink SHALL toggle on each sec_tic and SHALL be forced 0 for the cycle following each inc event, so the value stays visible while adjusting.
REQ-032 If sec_tic and btn_mode coincide, the state change SHALL take priority: blink=0 and the timeout counter=0.

Reset
REQ-033 While reset is high, at the clock edge, the outputs SHALL be: state=RUN, run_en=1, sec_clr=0, min_inc=0, hour_inc=0, blink=0, mode=00.
REQ-034 While reset is high, at the clock edge, the hold, timeout and edge registers SHALL all be 0.
REQ-035 Reset asserted mid-operation (including during auto-repeat) SHALL abandon it immediately, with no pulse emitted in the following cycle.
REQ-036 After reset deasserts, btn_inc already held high SHALL NOT count as a rising edge.

Verification
REQ-037 Bench scenario: reset, then btn_mode x1 -> mode=01, run_en=0, sec_clr=1 for one cycle; btn_mode x2 more -> mode=10, then 00, with run_en=1 again.
REQ-038 Bench scenario: in SET_MIN, btn_inc held for P_HOLD+3*P_RATE cycles (P_HOLD=20, P_RATE=5) -> exactly 4 min_inc pulses, with the first one cycle after the rising edge.
REQ-039 Bench scenario: in SET_HOUR, btn_mode and a btn_inc rising edge in the same cycle -> mode=00 and no hour_inc pulse.
REQ-040 Bench scenario: in SET_MIN with no buttons, P_TIMEOUT=3 and 3 sec_tic pulses -> mode=00 the cycle after the 3rd tic; blink toggled 0->1->0 before the exit.
REQ-041 Bench scenario: in RUN, btn_inc pulses -> no min_inc/hour_inc pulses, and mode stays 00.
REQ-042 Bench scenario: reset asserted during auto-repeat in SET_MIN -> the next cycle shows all outputs at reset values, with no further min_inc pulses while btn_inc stays held.
